// File: rtl/iq_decim_pack.sv
// iq_decim_pack: aligns the I/Q FIR streams, decimates by a runtime ratio, requantises and
// packs {I,Q} into an FWFT output FIFO. Define IQ_ROUND_SAT_EN for round-half-up + saturation.

module iq_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // A push into a full FIFO with a simultaneous pop reuses the slot being read out.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
endmodule

module iq_decim_pack #(
    parameter int IN_W       = 20,
    parameter int OUT_W      = 16,
    parameter int DEC_MAX    = 16,
    parameter int SKEW_DEPTH = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_valid,
    input  logic [IN_W-1:0]               i_data,
    input  logic                          q_valid,
    input  logic [IN_W-1:0]               q_data,
    input  logic [$clog2(DEC_MAX+1)-1:0]  dec_ratio,
    input  logic                          clr_err,
    output logic [2*OUT_W-1:0]            out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          align_err,
    output logic                          ovf_err
);
    localparam int CW = $clog2(DEC_MAX+1);
    localparam int SW = $clog2(SKEW_DEPTH) + 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] N_MAX  = CW'(DEC_MAX);
    localparam logic [CW-1:0] ONE    = 1;
    localparam logic [SW-1:0] SK_FULL = SW'(SKEW_DEPTH);
    localparam logic [LW-1:0] O_FULL  = LW'(FIFO_DEPTH);

    // Channel index 1 is I, 0 is Q, so packing order falls out of the array layout.
    logic [1:0]                 in_vld, sk_empty, sk_full, sk_push;
    logic [1:0][IN_W-1:0]       in_data, sk_head, pair_d;
    logic [1:0][SW-1:0]         sk_level;
    logic [1:0][OUT_W-1:0]      q_out;
    logic                       pair_pop, skew_ovf, pair_vld;

    assign in_vld   = {i_valid, q_valid};
    assign in_data  = {i_data, q_data};
    assign pair_pop = ~|sk_empty;
    // A full FIFO that is also popping this cycle still has room.
    assign skew_ovf = |(in_vld & sk_full) & ~pair_pop;
    assign sk_push  = in_vld & {2{~skew_ovf}};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        iq_fifo #(.W(IN_W), .DEPTH(SKEW_DEPTH)) u_skew (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (skew_ovf),
            .push    (sk_push[c]),
            .din     (in_data[c]),
            .pop     (pair_pop),
            .dout    (sk_head[c]),
            .level   (sk_level[c])
        );
        assign sk_empty[c] = (sk_level[c] == '0);
        assign sk_full[c]  = (sk_level[c] == SK_FULL);

`ifdef IQ_ROUND_SAT_EN
        localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (IN_W-OUT_W-1);
        logic [IN_W:0] rnd;
        assign rnd = {pair_d[c][IN_W-1], pair_d[c]} + HALF;
        // Sign-extension mismatch only occurs on positive overflow with half-up rounding.
        assign q_out[c] = (rnd[IN_W] ^ rnd[IN_W-1]) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                    : rnd[IN_W-1 -: OUT_W];
`else
        logic unused_lsb;
        assign unused_lsb = ^pair_d[c][IN_W-OUT_W-1:0];
        assign q_out[c]   = pair_d[c][IN_W-1 -: OUT_W];
`endif
    end

    // Decimation: the ratio is sampled at the first pair of each frame and held for the frame.
    logic [CW-1:0] cnt, n_lat, n_req, n_eff;
    logic          frame_end;

    assign n_req     = (dec_ratio > N_MAX) ? N_MAX : dec_ratio;
    assign n_eff     = (cnt == '0) ? n_req : n_lat;
    assign frame_end = (n_eff <= ONE) || (cnt == n_eff - ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            n_lat <= '0;
        end else if (skew_ovf) begin
            cnt <= '0;
        end else if (pair_pop) begin
            if (cnt == '0) n_lat <= n_req;
            cnt <= frame_end ? '0 : cnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_vld <= 1'b0;
            pair_d   <= '0;
        end else begin
            pair_vld <= pair_pop && (cnt == '0);
            if (pair_pop) pair_d <= sk_head;
        end
    end

    logic [2*OUT_W-1:0] o_head;
    logic               o_full, rd_pop, o_push, ovf_evt;

    assign o_full  = (fifo_level == O_FULL);
    assign rd_pop  = out_valid & out_ready;
    assign o_push  = pair_vld & (~o_full | rd_pop);
    assign ovf_evt = pair_vld & o_full & ~rd_pop;

    iq_fifo #(.W(2*OUT_W), .DEPTH(FIFO_DEPTH)) u_out (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (1'b0),
        .push    (o_push),
        .din     ({q_out[1], q_out[0]}),
        .pop     (rd_pop),
        .dout    (o_head),
        .level   (fifo_level)
    );

    assign out_valid = (fifo_level != '0);
    assign out_data  = out_valid ? o_head : '0;

    // Sticky flags: a new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            align_err <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            align_err <= skew_ovf | (align_err & ~clr_err);
            ovf_err   <= ovf_evt  | (ovf_err & ~clr_err);
        end
    end
endmodule

// File: tb/tb_iq_decim_pack.sv
// Directed self-checking bench for iq_decim_pack (default parameters).
module tb_iq_decim_pack;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_valid, q_valid;
    logic [19:0] i_data, q_data;
    logic [4:0]  dec_ratio;
    logic        clr_err;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic        align_err, ovf_err;

    int checks = 0;
    int errors = 0;

    iq_decim_pack dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .q_valid    (q_valid),
        .q_data     (q_data),
        .dec_ratio  (dec_ratio),
        .clr_err    (clr_err),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .align_err  (align_err),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [19:0] iv, input logic [19:0] qv);
        i_valid = 1'b1; q_valid = 1'b1; i_data = iv; q_data = qv;
        tick();
        i_valid = 1'b0; q_valid = 1'b0;
    endtask

    // Waits (bounded) for a word, captures it and pops it.
    task automatic pop_word(output logic [31:0] w, output bit got);
        got = 1'b0;
        w   = '0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                w = out_data; got = 1'b1;
                break;
            end
            tick();
        end
        if (got) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_valid = 0; q_valid = 0; i_data = '0; q_data = '0;
        dec_ratio = 5'd1; clr_err = 0; out_ready = 0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if ({align_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {align_err, ovf_err}); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        logic [31:0] w; bit got;
        dec_ratio = 5'd1;
        i_valid = 1; q_valid = 1; i_data = 20'h12345; q_data = 20'h12345;
        tick();
        i_valid = 0; q_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c1 got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c2 got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_c3 got %b exp 1", out_valid); end
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL lat_level got %0d exp 1", fifo_level); end
        pop_word(w, got);
        checks++; if (!got || w !== 32'h1234_1234) begin errors++; $display("FAIL lat_data got %h exp 12341234", w); end
    endtask

    task automatic test_decim();
        logic [19:0] v; logic [15:0] e; logic [31:0] w; bit got;
        dec_ratio = 5'd4;
        for (int k = 0; k < 16; k++) begin
            v = 20'(k * 16);
            send_pair(v, -v);
        end
        repeat (4) tick();
        checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL decim_level got %0d exp 4", fifo_level); end
        for (int j = 0; j < 4; j++) begin
            e = 16'(4 * j);
            pop_word(w, got);
            checks++; if (!got || w !== {e, -e}) begin errors++; $display("FAIL decim_word%0d got %h exp %h", j, w, {e, -e}); end
        end
        dec_ratio = 5'd1;
    endtask

    task automatic test_align();
        logic [31:0] w; bit got;
        // I leads Q by 3 cycles: fits in the skew FIFO.
        for (int t = 0; t < 7; t++) begin
            i_valid = (t < 4);  i_data = 20'((32'h100 + t) << 4);
            q_valid = (t >= 3); q_data = 20'((32'h200 + t - 3) << 4);
            tick();
        end
        i_valid = 0; q_valid = 0;
        repeat (4) tick();
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL skew3_align_err got %b exp 0", align_err); end
        checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL skew3_level got %0d exp 4", fifo_level); end
        for (int k = 0; k < 4; k++) begin
            pop_word(w, got);
            checks++; if (!got || w !== {16'(16'h0100 + k), 16'(16'h0200 + k)}) begin
                errors++; $display("FAIL skew3_word%0d got %h exp %h", k, w, {16'(16'h0100 + k), 16'(16'h0200 + k)}); end
        end
        // I leads by 5: overflow on the 5th sample, with clr_err held in that same cycle.
        for (int t = 0; t < 5; t++) begin
            i_valid = 1; i_data = 20'((32'h700 + t) << 4);
            clr_err = (t == 4);
            tick();
        end
        i_valid = 0; clr_err = 0;
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL skew5_align_err got %b exp 1", align_err); end
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skew5_no_output got %b exp 0", out_valid); end
        send_pair(20'h03000, 20'h04000);
        pop_word(w, got);
        checks++; if (!got || w !== 32'h0300_0400) begin errors++; $display("FAIL skew5_resume got %h exp 03000400", w); end
        repeat (3) tick();
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL skew5_stale got %0d exp 0", fifo_level); end
        clr_err = 1; tick(); clr_err = 0;
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_clr got %b exp 0", align_err); end
    endtask

    task automatic test_ovf();
        logic [31:0] w; bit got;
        out_ready = 0;
        for (int k = 1; k <= 10; k++) send_pair(20'(k * 16), 20'((k + 32'h50) * 16));
        repeat (4) tick();
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", fifo_level); end
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf_err); end
        checks++; if (out_data !== 32'h0001_0051) begin errors++; $display("FAIL ovf_head got %h exp 00010051", out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0001_0051) begin
            errors++; $display("FAIL ovf_hold got %b/%h exp 1/00010051", out_valid, out_data); end
        for (int k = 1; k <= 8; k++) begin
            pop_word(w, got);
            checks++; if (!got || w !== {16'(k), 16'(k + 16'h50)}) begin
                errors++; $display("FAIL ovf_drain%0d got %h exp %h", k, w, {16'(k), 16'(k + 16'h50)}); end
        end
        tick();
        checks++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL ovf_lost got %b/%0d exp 0/0", out_valid, fifo_level); end
        clr_err = 1; tick(); clr_err = 0;
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", ovf_err); end
    endtask

    task automatic test_quant();
        logic [31:0] w, e0, e1; bit got;
`ifdef IQ_ROUND_SAT_EN
        e0 = 32'h7FFF_0002; e1 = 32'h8000_0000;
`else
        e0 = 32'h7FFF_0001; e1 = 32'h8000_FFFF;
`endif
        dec_ratio = 5'd0;
        send_pair(20'h7FFFF, 20'h00018);
        send_pair(20'h80000, 20'hFFFF8);
        pop_word(w, got);
        checks++; if (!got || w !== e0) begin errors++; $display("FAIL quant_pos got %h exp %h", w, e0); end
        pop_word(w, got);
        checks++; if (!got || w !== e1) begin errors++; $display("FAIL quant_neg got %h exp %h", w, e1); end
        dec_ratio = 5'd1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] w; bit got;
        out_ready = 0;
        for (int k = 0; k < 4; k++) send_pair(20'h11110, 20'h22220);
        repeat (3) tick();
        checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL mid_prefill got %0d exp 4", fifo_level); end
        i_valid = 1; q_valid = 1;
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL mid_rst_out got %b/%h exp 0/0", out_valid, out_data); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL mid_rst_level got %0d exp 0", fifo_level); end
        i_valid = 0; q_valid = 0;
        tick();
        reset_n = 1'b1;
        tick();
        i_valid = 1; q_valid = 1; i_data = 20'hABCDE; q_data = 20'h13579;
        tick();
        i_valid = 0; q_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_c1 got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_c2 got %b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || fifo_level !== 4'd1) begin
            errors++; $display("FAIL post_rst_c3 got %b/%0d exp 1/1", out_valid, fifo_level); end
        pop_word(w, got);
        checks++; if (!got || w !== 32'hABCD_1357) begin errors++; $display("FAIL post_rst_data got %h exp abcd1357", w); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_decim();
        test_align();
        test_ovf();
        test_quant();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
